// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box word substitution, word rotation, round constants,
// the key-schedule temp function and the reverse-stream key FSM state type.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2,
        REV  = 2'd3
    } aes_krs_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] SubWord(input logic [31:0] x);
        SubWord = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [31:0] RotWord(input logic [31:0] x);
        RotWord = {x[23:0], x[31:24]};
    endfunction

    function automatic logic [31:0] RCON(input logic [3:0] n);
        case (n)
            4'd1:    RCON = 32'h01000000;
            4'd2:    RCON = 32'h02000000;
            4'd3:    RCON = 32'h04000000;
            4'd4:    RCON = 32'h08000000;
            4'd5:    RCON = 32'h10000000;
            4'd6:    RCON = 32'h20000000;
            4'd7:    RCON = 32'h40000000;
            4'd8:    RCON = 32'h80000000;
            4'd9:    RCON = 32'h1b000000;
            4'd10:   RCON = 32'h36000000;
            default: RCON = 32'h00000000;
        endcase
    endfunction

    // Rotation is applied before a single SubWord so one S-box word path serves both substituting cases.
    function automatic logic [31:0] KeyTemp(input logic [31:0] word, input logic [5:0] i, input int nk);
        int          idx;
        int          pos;
        int          rnd;
        logic [31:0] sub_in;
        logic [31:0] sub_out;
        idx = int'({26'd0, i});
        pos = idx % nk;
        rnd = idx / nk;
        if (pos == 0) begin
            sub_in = RotWord(word);
        end else begin
            sub_in = word;
        end
        sub_out = SubWord(sub_in);
        if (pos == 0) begin
            KeyTemp = sub_out ^ RCON(4'(rnd));
        end else if (nk > 6 && pos == 4) begin
            KeyTemp = sub_out;
        end else begin
            KeyTemp = word;
        end
    endfunction

endpackage

// File: rtl/aes_key_rev_stream.sv
// Iterative AES key schedule streaming round keys Nr..0: expands forward to the
// last round key, then inverts the recurrence one word per cycle.
module aes_key_rev_stream
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [32*Nk-1:0]  key,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_idx,
    output logic              rk_last
);

    localparam logic [5:0] FWD_END = 6'(4 * (Nr + 1) - Nk);

    aes_krs_state_t    state_r;
    aes_krs_state_t    state_s;
    logic [31:0]       win_r [Nk];
    logic [31:0]       win_s [Nk];
    logic [5:0]        base_r;
    logic [5:0]        base_s;
    logic [3:0]        idx_r;
    logic [3:0]        idx_s;
    logic              busy_r;
    logic              valid_r;
    logic              last_r;
    logic [127:0]      data_r;
    logic [127:0]      data_s;
    logic [31:0]       fwd_word_s;
    logic [31:0]       rev_word_s;
    logic signed [6:0] offset_s;

    assign fwd_word_s = win_r[0] ^ KeyTemp(win_r[Nk-1], base_r + 6'(Nk), Nk);
    assign rev_word_s = win_r[Nk-1] ^ KeyTemp(win_r[Nk-2], base_r + 6'(Nk - 1), Nk);

    // Next state, window, base index and round index.
    always_comb begin
        state_s = state_r;
        win_s   = win_r;
        base_s  = base_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    for (int j = 0; j < Nk; j++) begin
                        win_s[j] = key[32*j +: 32];
                    end
                    base_s  = 6'd0;
                    idx_s   = 4'(Nr);
                    state_s = FWD;
                end else begin
                    state_s = IDLE;
                end
            end
            FWD: begin
                for (int j = 0; j < Nk - 1; j++) begin
                    win_s[j] = win_r[j+1];
                end
                win_s[Nk-1] = fwd_word_s;
                base_s      = base_r + 6'd1;
                if (base_s == FWD_END) begin
                    state_s = EMIT;
                end else begin
                    state_s = FWD;
                end
            end
            REV: begin
                for (int j = 1; j < Nk; j++) begin
                    win_s[j] = win_r[j-1];
                end
                win_s[0] = rev_word_s;
                base_s   = base_r - 6'd1;
                if ({idx_r, 2'b00} >= base_s) begin
                    state_s = EMIT;
                end else begin
                    state_s = REV;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_r == 4'd0) begin
                        state_s = IDLE;
                    end else begin
                        idx_s = idx_r - 4'd1;
                        if ({idx_s, 2'b00} >= base_r) begin
                            state_s = EMIT;
                        end else begin
                            state_s = REV;
                        end
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign offset_s = $signed({1'b0, idx_s, 2'b00}) - $signed({1'b0, base_s});

    // Select the next round key out of the next window so rk_data can be registered.
    always_comb begin
        data_s = data_r;
        for (int s = 0; s <= Nk - 4; s++) begin
            if (state_s == EMIT && offset_s == 7'(s)) begin
                for (int k = 0; k < 4; k++) begin
                    data_s[32*k +: 32] = win_s[s+k];
                end
            end else begin
                data_s = data_s;
            end
        end
    end

    // FSM, window and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            base_r  <= 6'd0;
            idx_r   <= 4'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            data_r  <= 128'd0;
            for (int j = 0; j < Nk; j++) begin
                win_r[j] <= 32'd0;
            end
        end else begin
            state_r <= state_s;
            base_r  <= base_s;
            idx_r   <= idx_s;
            busy_r  <= (state_s != IDLE);
            valid_r <= (state_s == EMIT);
            last_r  <= (state_s == EMIT) && (idx_s == 4'd0);
            data_r  <= data_s;
            win_r   <= win_s;
        end
    end

    assign busy     = busy_r;
    assign rk_valid = valid_r;
    assign rk_last  = last_r;
    assign rk_data  = data_r;
    assign rk_idx   = idx_r;

endmodule

// File: tb/tb_aes_key_rev_stream.sv
// Bench for aes_key_rev_stream: three instances (Nk=4/6/8) checked against an
// independent forward key expansion with a computed S-box.
module tb_aes_key_rev_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   load_v;
    logic [255:0] key_bus;
    logic         ready;
    logic         busy_m  [3];
    logic         valid_m [3];
    logic         last_m  [3];
    logic [127:0] data_m  [3];
    logic [3:0]   idx_m   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_rev_stream #(.Nk(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load_v[0]), .key(key_bus[127:0]),
        .busy(busy_m[0]), .rk_valid(valid_m[0]), .rk_ready(ready),
        .rk_data(data_m[0]), .rk_idx(idx_m[0]), .rk_last(last_m[0]));
    aes_key_rev_stream #(.Nk(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .load(load_v[1]), .key(key_bus[191:0]),
        .busy(busy_m[1]), .rk_valid(valid_m[1]), .rk_ready(ready),
        .rk_data(data_m[1]), .rk_idx(idx_m[1]), .rk_last(last_m[1]));
    aes_key_rev_stream #(.Nk(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .load(load_v[2]), .key(key_bus),
        .busy(busy_m[2]), .rk_valid(valid_m[2]), .rk_ready(ready),
        .rk_data(data_m[2]), .rk_idx(idx_m[2]), .rk_last(last_m[2]));

    typedef struct {
        logic [127:0] data;
        logic [3:0]   idx;
        logic         last;
        int           gap;
    } exp_t;

    typedef struct {
        int           sel;
        int           nk;
        logic [255:0] key;
        logic [127:0] first_rk;
        bit           anchored;
        bit           stalls;
        bit           poke;
        int           abort_after;
    } vec_t;

    exp_t        sbq[$];
    logic [7:0]  sb [256];
    logic [31:0] ew [60];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input int nk, input logic [255:0] k);
        logic [7:0]  rc;
        logic [31:0] t;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) ew[i] = k[32*i +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = ew[i-1];
            if (i % nk == 0) begin
                t  = sub({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub(t);
            end
            ew[i] = ew[i-nk] ^ t;
        end
    endtask

    task automatic run_stream(input vec_t v);
        int           nr;
        int           b;
        int           e;
        int           gap_cnt;
        int           stall;
        int           n_xfer;
        int           first_edge;
        int           last_edge;
        int           gap_sum;
        int           zero_gaps;
        bit           busy_ok;
        bit           holding;
        bit           aborted;
        logic [127:0] held_d;
        logic [3:0]   held_i;
        exp_t         ex;
        nr = v.nk + 6;
        expand(v.nk, v.key);
        b = 4 * (nr + 1) - v.nk;
        gap_sum = 0;
        for (int r = nr; r >= 0; r--) begin
            ex.data = {ew[4*r+3], ew[4*r+2], ew[4*r+1], ew[4*r]};
            ex.idx  = 4'(r);
            ex.last = (r == 0);
            ex.gap  = 0;
            if (r < nr && b > 4 * r) begin
                ex.gap = b - 4 * r;
                b      = 4 * r;
            end
            gap_sum += ex.gap;
            sbq.push_back(ex);
        end
        first_edge = 4 * (nr + 1) - v.nk + 1;
        @(negedge clk);
        key_bus = v.key;
        load_v[v.sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_v[v.sel] = 1'b0;
        if (v.poke) key_bus = ~v.key;
        e = 1; gap_cnt = 0; stall = 0; n_xfer = 0; zero_gaps = 0; last_edge = 0;
        busy_ok = 1'b1; holding = 1'b0; aborted = 1'b0;
        while (sbq.size() > 0 && e < 3000) begin
            if (v.abort_after > 0 && n_xfer == v.abort_after && !valid_m[v.sel]) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", busy_m[v.sel], 1'b0);
                check("rst_valid", valid_m[v.sel], 1'b0);
                check("rst_last", last_m[v.sel], 1'b0);
                check("rst_data", data_m[v.sel], 128'd0);
                check("rst_idx", idx_m[v.sel], 4'd0);
                sbq.delete();
                aborted = 1'b1;
                break;
            end
            ready = v.stalls ? (stall == 0) : 1'b1;
            load_v[v.sel] = v.poke && (e == 12 || valid_m[v.sel]);
            if (busy_m[v.sel] !== 1'b1) busy_ok = 1'b0;
            if (valid_m[v.sel]) begin
                if (holding) begin
                    check("hold_data", data_m[v.sel], held_d);
                    check("hold_idx", idx_m[v.sel], held_i);
                end
                if (ready) begin
                    ex = sbq.pop_front();
                    check("rk_data", data_m[v.sel], ex.data);
                    check("rk_idx", idx_m[v.sel], ex.idx);
                    check("rk_last", last_m[v.sel], ex.last);
                    if (n_xfer == 0) begin
                        check("first_edge", e, first_edge);
                        if (v.anchored) check("first_key", data_m[v.sel], v.first_rk);
                    end else if (!v.stalls) begin
                        check("gap", gap_cnt, ex.gap);
                        if (gap_cnt == 0) zero_gaps++;
                    end
                    if (ex.last && v.anchored) check("last_is_key", data_m[v.sel], v.key[127:0]);
                    n_xfer++;
                    last_edge = e;
                    gap_cnt = 0;
                    holding = 1'b0;
                    if (v.stalls) stall = $urandom_range(0, 7);
                end else begin
                    held_d = data_m[v.sel];
                    held_i = idx_m[v.sel];
                    holding = 1'b1;
                    stall--;
                end
            end else begin
                if (holding) begin
                    check("hold_valid", valid_m[v.sel], 1'b1);
                    holding = 1'b0;
                end
                if (n_xfer > 0) gap_cnt++;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        load_v[v.sel] = 1'b0;
        ready = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end
        check("stream_done", sbq.size(), 0);
        sbq.delete();
        check("busy_during_stream", busy_ok, 1'b1);
        check("busy_after", busy_m[v.sel], 1'b0);
        check("valid_after", valid_m[v.sel], 1'b0);
        if (!v.stalls) check("last_edge", last_edge, first_edge + gap_sum + nr);
        if (v.nk == 8 && !v.stalls) check("b2b_seen", zero_gaps > 0, 1'b1);
        @(negedge clk);
        check("idle_stays", busy_m[v.sel], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt [9];
        logic [255:0] ka1;
        logic [255:0] ka2;
        logic [255:0] ka3;
        logic [255:0] kr;
        rst_n = 1'b0; load_v = 3'b000; ready = 1'b0; key_bus = 256'd0;
        build_sbox();
        ka1 = {128'd0, 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516};
        ka2 = {64'd0, 192'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7};
        ka3 = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;
        for (int i = 0; i < 8; i++) kr[32*i +: 32] = $urandom;
        kr[255:192] = 64'd0;
        vt[0] = '{0, 4, ka1, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8, 1'b1, 1'b0, 1'b0, 0};
        vt[1] = '{1, 6, ka2, 128'h01002202_8ecc7204_448c773c_e98ba06f, 1'b1, 1'b0, 1'b0, 0};
        vt[2] = '{2, 8, ka3, 128'h706c631e_046df344_e6188d0b_fe4890d1, 1'b1, 1'b0, 1'b0, 0};
        vt[3] = '{0, 4, ka1, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8, 1'b1, 1'b1, 1'b0, 0};
        vt[4] = '{2, 8, ka3, 128'h706c631e_046df344_e6188d0b_fe4890d1, 1'b1, 1'b1, 1'b0, 0};
        vt[5] = '{1, 6, kr, 128'd0, 1'b0, 1'b1, 1'b1, 0};
        vt[6] = '{0, 4, ka1, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8, 1'b1, 1'b0, 1'b1, 0};
        vt[7] = '{0, 4, ka1, 128'd0, 1'b0, 1'b0, 1'b0, 3};
        vt[8] = '{0, 4, ka1, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8, 1'b1, 1'b0, 1'b0, 0};

        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_busy", busy_m[d], 1'b0);
            check("reset_valid", valid_m[d], 1'b0);
            check("reset_data", data_m[d], 128'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_stream(vt[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
